// File: rtl/tt_sweep_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_reader_if
// Brief    : Bundle between the truth-table sweep reader, its FUT and scoreboard.
// Revision : 1.0
// ============================================================================
// The assembled table is named truth_table because "table" is a reserved word.
interface tt_sweep_reader_if;
    logic         start;
    logic [127:0] expected;
    logic         x0;
    logic         x1;
    logic         x2;
    logic         x3;
    logic         x4;
    logic         x5;
    logic         x6;
    logic         out;
    logic         busy;
    logic         done;
    logic [127:0] truth_table;
    logic         match;
    logic [7:0]   weight;

    modport master (
        output start, expected, out,
        input  x0, x1, x2, x3, x4, x5, x6, busy, done, truth_table, match, weight
    );

    modport slave (
        input  start, expected, out,
        output x0, x1, x2, x3, x4, x5, x6, busy, done, truth_table, match, weight
    );
endinterface
`default_nettype wire

// File: rtl/tt_sweep_reader.sv
`default_nettype none
// ============================================================================
// Module   : tt_sweep_reader
// Brief    : Drives all 128 minterms into a FUT, assembles its truth table,
//            and reports match against a reference plus onset weight.
// Revision : 1.0
// ============================================================================
module tt_sweep_reader #(
    parameter int LAT = 0
) (
    input  logic              clk,
    input  logic              rst,
    tt_sweep_reader_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] c_drain_last = (LAT > 0) ? 3'(LAT - 1) : 3'd0;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [6:0]   r_idx;
    logic [2:0]   r_drain;
    logic [127:0] r_expected;
    logic [127:0] r_table;
    logic [127:0] w_table_nxt;
    logic [7:0]   r_weight;
    logic [7:0]   w_weight_nxt;
    logic         r_match;
    logic         w_accept;
    logic         w_enter_done;
    logic         w_drive;
    logic         w_smp_vld;
    logic [6:0]   w_smp_idx;
    logic [6:0]   w_x;

    assign w_accept = bus.start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_drive  = (r_state == S_SWEEP) || (r_state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_enter_done = 1'b0;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nxt = S_SWEEP;
            S_SWEEP: if (r_idx == 7'd127) w_state_nxt = (LAT == 0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (r_drain == c_drain_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = bus.start ? S_SWEEP : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        if (w_drive && (w_state_nxt == S_DONE)) begin
            w_enter_done = 1'b1;
        end
    end

    // Valid/index delay line aligns each sample with the FUT response latency.
    generate
        if (LAT == 0) begin : g_lat_zero
            assign w_smp_vld = (r_state == S_SWEEP);
            assign w_smp_idx = r_idx;
        end else begin : g_lat_pipe
            logic [LAT-1:0] r_dv;
            logic [6:0]     r_di [LAT];

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_dv <= '0;
                    for (int k = 0; k < LAT; k++) r_di[k] <= '0;
                end else begin
                    r_dv[0] <= (r_state == S_SWEEP);
                    r_di[0] <= r_idx;
                    for (int k = 1; k < LAT; k++) begin
                        r_dv[k] <= r_dv[k-1];
                        r_di[k] <= r_di[k-1];
                    end
                end
            end

            assign w_smp_vld = r_dv[LAT-1];
            assign w_smp_idx = r_di[LAT-1];
        end
    endgenerate

    always_comb begin
        w_table_nxt  = r_table;
        w_weight_nxt = r_weight;
        if (w_smp_vld) begin
            w_table_nxt[w_smp_idx] = bus.out;
            w_weight_nxt           = r_weight + {7'd0, bus.out};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx      <= '0;
            r_drain    <= '0;
            r_expected <= '0;
            r_table    <= '0;
            r_weight   <= '0;
            r_match    <= 1'b0;
        end else if (w_accept) begin
            r_expected <= bus.expected;
            r_table    <= '0;
            r_weight   <= '0;
            r_match    <= 1'b0;
            r_idx      <= '0;
            r_drain    <= '0;
        end else begin
            if ((r_state == S_SWEEP) && (r_idx != 7'd127)) r_idx <= r_idx + 7'd1;
            r_drain  <= (r_state == S_DRAIN) ? r_drain + 3'd1 : 3'd0;
            r_table  <= w_table_nxt;
            r_weight <= w_weight_nxt;
            // Compare the table including the final sample landing on this edge.
            if (w_enter_done) r_match <= (w_table_nxt == r_expected);
        end
    end

    assign w_x = w_drive ? r_idx : 7'd0;
    assign {bus.x6, bus.x5, bus.x4, bus.x3, bus.x2, bus.x1, bus.x0} = w_x;
    assign bus.busy        = w_drive;
    assign bus.done        = (r_state == S_DONE);
    assign bus.truth_table = r_table;
    assign bus.match       = r_match;
    assign bus.weight      = r_weight;

endmodule
`default_nettype wire
